// File: rtl/adder_pipe.sv
// adder_pipe: pipelined unsigned adder/subtractor with valid/ready handshaking.
// The WIDTH-bit add is split into STAGES slices of WIDTH/STAGES bits. Each
// stage adds one slice and passes its carry to the next stage. The whole
// pipeline freezes while the output holds an unconsumed result.
//
// Ports:
//   clk        clock, rising-edge active
//   rst        asynchronous active-high reset
//   in_valid   operand beat present
//   in_ready   block can accept a beat this cycle (combinational)
//   in_a       operand A, unsigned
//   in_b       operand B, unsigned
//   in_sub     0: A+B, 1: A-B
//   out_valid  result beat present
//   out_ready  consumer accepts the result this cycle
//   out_data   WIDTH+1 bit result (two's complement for subtract)
//   out_sub    in_sub of the beat on the output
module adder_pipe #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_data,
   output logic             out_sub
);

   localparam int unsigned C = WIDTH / STAGES;

   generate
      if ((WIDTH < 2) || ((WIDTH % STAGES) != 0)) begin : g_param_check
         $error("adder_pipe: WIDTH must be >= 2 and divisible by STAGES");
      end
   endgenerate

   // Per-stage registers. Operands travel whole; stage k only consumes slice k.
   logic             r_valid [STAGES];
   logic             r_sub   [STAGES];
   logic             r_carry [STAGES];
   logic [WIDTH-1:0] r_a     [STAGES];
   logic [WIDTH-1:0] r_b     [STAGES];
   logic [WIDTH-1:0] r_res   [STAGES];
   logic             r_msb;

   // Combinational view of what enters each stage.
   logic             w_valid_in [STAGES];
   logic             w_sub_in   [STAGES];
   logic             w_cin      [STAGES];
   logic [WIDTH-1:0] w_a_in     [STAGES];
   logic [WIDTH-1:0] w_b_in     [STAGES];
   logic [WIDTH-1:0] w_res_in   [STAGES];
   logic [C:0]       w_sum      [STAGES];
   logic [WIDTH-1:0] w_res_nxt  [STAGES];
   logic             w_msb_nxt;
   logic             w_stall;

   assign w_stall   = out_valid & ~out_ready;
   assign in_ready  = ~w_stall;
   assign out_valid = r_valid[STAGES-1];
   assign out_sub   = r_sub[STAGES-1];
   assign out_data  = {r_msb, r_res[STAGES-1]};

   // Stage 0 takes the ports directly; stage k takes the registers of stage k-1.
   // The carry-in of stage 0 is the +1 of the two's-complement subtract.
   always_comb begin : p_stage_inputs
      w_valid_in[0] = in_valid;
      w_sub_in[0]   = in_sub;
      w_cin[0]      = in_sub;
      w_a_in[0]     = in_a;
      w_b_in[0]     = in_b;
      w_res_in[0]   = '0;
      for (int unsigned k = 1; k < STAGES; k++) begin
         w_valid_in[k] = r_valid[k-1];
         w_sub_in[k]   = r_sub[k-1];
         w_cin[k]      = r_carry[k-1];
         w_a_in[k]     = r_a[k-1];
         w_b_in[k]     = r_b[k-1];
         w_res_in[k]   = r_res[k-1];
      end
   end

   // Slice add. B is inverted for subtract. The top bit uses the zero extension
   // bits: 0 + (sub ? 1 : 0) + final carry, taken mod 2.
   always_comb begin : p_slice_add
      for (int unsigned k = 0; k < STAGES; k++) begin
         w_sum[k] = (C+1)'(w_a_in[k][k*C +: C])
                  + (C+1)'(w_b_in[k][k*C +: C] ^ {C{w_sub_in[k]}})
                  + (C+1)'(w_cin[k]);
         w_res_nxt[k]             = w_res_in[k];
         w_res_nxt[k][k*C +: C]   = w_sum[k][C-1:0];
      end
      w_msb_nxt = w_sub_in[STAGES-1] ^ w_sum[STAGES-1][C];
   end

   // Pipeline registers. Valid bits advance on every unstalled edge.
   // Data registers load only with a valid beat, so the output holds across bubbles.
   always_ff @(posedge clk or posedge rst) begin : p_pipe
      if (rst) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            r_valid[k] <= 1'b0;
            r_sub[k]   <= 1'b0;
            r_carry[k] <= 1'b0;
            r_a[k]     <= '0;
            r_b[k]     <= '0;
            r_res[k]   <= '0;
         end
         r_msb <= 1'b0;
      end else if (!w_stall) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            r_valid[k] <= w_valid_in[k];
            if (w_valid_in[k]) begin
               r_sub[k]   <= w_sub_in[k];
               r_carry[k] <= w_sum[k][C];
               r_a[k]     <= w_a_in[k];
               r_b[k]     <= w_b_in[k];
               r_res[k]   <= w_res_nxt[k];
            end
         end
         if (w_valid_in[STAGES-1]) begin
            r_msb <= w_msb_nxt;
         end
      end
   end

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: scoreboard bench for adder_pipe.
// The main instance uses WIDTH=16 and STAGES=4. Two small instances cover the
// WIDTH=4/STAGES=1 and WIDTH=8/STAGES=8 corners.
module tb_adder_pipe;

   localparam int unsigned W = 16;
   localparam int unsigned S = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic           in_valid, in_ready, in_sub, out_valid, out_ready, out_sub;
   logic [W-1:0]   in_a, in_b;
   logic [W:0]     out_data;

   logic           s4_valid, s4_ready, s4_sub, s4_out_valid, s4_out_sub;
   logic [3:0]     s4_a, s4_b;
   logic [4:0]     s4_out_data;
   logic           s8_valid, s8_ready, s8_sub, s8_out_valid, s8_out_sub;
   logic [7:0]     s8_a, s8_b;
   logic [8:0]     s8_out_data;
   logic           s_out_ready = 1'b1;

   adder_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_sub(out_sub));

   adder_pipe #(.WIDTH(4), .STAGES(1)) u_w4 (
      .clk(clk), .rst(rst), .in_valid(s4_valid), .in_ready(s4_ready),
      .in_a(s4_a), .in_b(s4_b), .in_sub(s4_sub), .out_valid(s4_out_valid),
      .out_ready(s_out_ready), .out_data(s4_out_data), .out_sub(s4_out_sub));

   adder_pipe #(.WIDTH(8), .STAGES(8)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(s8_valid), .in_ready(s8_ready),
      .in_a(s8_a), .in_b(s8_b), .in_sub(s8_sub), .out_valid(s8_out_valid),
      .out_ready(s_out_ready), .out_data(s8_out_data), .out_sub(s8_out_sub));

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int stall_cnt = 0;

   typedef struct {
      logic [W:0] data;
      logic       sub;
      int         acc_edge;
      int         stall_mark;
   } exp_t;
   exp_t exp_q[$];

   // Reference: plain integer add/subtract, wrapped to WIDTH+1 bits.
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic sub);
      longint d;
      d = sub ? (longint'(a) - longint'(b)) : (longint'(a) + longint'(b));
      return (W+1)'(d);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: log accepted beats and score results at the falling edge.
   // Latency is STAGES edges from acceptance to retirement plus one per stall edge.
   always @(negedge clk) begin
      if (!rst) begin
         check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
         if (out_valid && !out_ready) stall_cnt++;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious: out_valid=1 data %0h with no beat pending (t=%0t)",
                        out_data, $time);
            end else begin
               check("out_data", 64'(out_data), 64'(exp_q[0].data));
               check("out_sub", 64'(out_sub), 64'(exp_q[0].sub));
               if (out_ready) begin
                  check("latency", 64'(cyc + 1 - exp_q[0].acc_edge),
                        64'(int'(S) + stall_cnt - exp_q[0].stall_mark));
                  void'(exp_q.pop_front());
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back('{data: model(in_a, in_b, in_sub), sub: in_sub,
                              acc_edge: cyc + 1, stall_mark: stall_cnt});
         end
      end
   end

   // Present a beat and hold it until the monitor sees it will be accepted.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_sub = s;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) break;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a = W'($urandom);
      in_b = W'($urandom);
      in_sub = 1'($urandom);
   endtask

   task automatic drain();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         if (exp_q.size() == 0) break;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic small4(input logic [3:0] a, input logic [3:0] b, input logic [4:0] expv);
      int n;
      @(posedge clk);
      #1;
      s4_valid = 1'b1; s4_a = a; s4_b = b; s4_sub = 1'b0;
      @(posedge clk);
      #1;
      s4_valid = 1'b0;
      n = 1;
      while (!s4_out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("w4_latency", 64'(n), 64'd1);
      check("w4_data", 64'(s4_out_data), 64'(expv));
   endtask

   task automatic small8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                         input logic [8:0] expv);
      int n;
      @(posedge clk);
      #1;
      s8_valid = 1'b1; s8_a = a; s8_b = b; s8_sub = sub;
      @(posedge clk);
      #1;
      s8_valid = 1'b0;
      n = 1;
      while (!s8_out_valid && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("w8_latency", 64'(n), 64'd8);
      check("w8_data", 64'(s8_out_data), 64'(expv));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
      s4_valid = 1'b0; s4_a = '0; s4_b = '0; s4_sub = 1'b0;
      s8_valid = 1'b0; s8_a = '0; s8_b = '0; s8_sub = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_sub", 64'(out_sub), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      #20 rst = 1'b0;

      // Single add, then the arithmetic extremes.
      send(16'd3, 16'd4, 1'b0);
      drain();
      send(16'hFFFF, 16'hFFFF, 1'b0);
      send(16'h0005, 16'h0009, 1'b1);
      send(16'hFFFF, 16'h0000, 1'b1);
      send(16'h0000, 16'hFFFF, 1'b1);
      drain();

      // Back-to-back random stream with the consumer always ready.
      for (int i = 0; i < 100; i++) send(W'($urandom), W'($urandom), 1'($urandom));
      drain();

      // Five-cycle stall in the middle of a burst.
      fork
         for (int i = 0; i < 20; i++) send(W'($urandom), W'($urandom), 1'($urandom));
         begin
            repeat (8) @(posedge clk);
            #2 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #2 out_ready = 1'b1;
         end
      join
      drain();

      // Random bubbles and random backpressure together.
      fork
         for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else send(W'($urandom), W'($urandom), 1'($urandom));
         end
         begin
            for (int j = 0; j < 200; j++) begin
               @(posedge clk);
               #2 out_ready = ($urandom_range(0, 2) != 0);
            end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      drain();

      // Reset with three beats in flight.
      send(16'h1234, 16'h1111, 1'b0);
      send(16'h0100, 16'h0200, 1'b1);
      send(16'hABCD, 16'h0001, 1'b0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      #2 rst = 1'b1;
      exp_q.delete();
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_out_data", 64'(out_data), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      #20 rst = 1'b0;
      repeat (10) idle();
      send(16'h0F0F, 16'h00F1, 1'b0);
      drain();

      // Other parameterisations.
      small4(4'd9, 4'd11, 5'd20);
      small4(4'd15, 4'd15, 5'd30);
      repeat (2) @(posedge clk);
      small8(8'h80, 8'h01, 1'b1, 9'h07F);
      repeat (10) @(posedge clk);
      small8(8'hFF, 8'hFF, 1'b0, 9'h1FE);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
